// File: rtl/pid_pkg.sv
// Shared constants and sample type for the PID controller terms.
package pid_pkg;

    localparam int E_W    = 8;              // error sample width
    localparam int K_W    = 8;              // gain width (unsigned)
    localparam int FRAC   = 2;              // fraction bits of the gain
    localparam int OUT_W  = 8;              // contribution width
    localparam int DIFF_W = E_W + 1;        // e - e_prev never overflows this
    localparam int PROD_W = DIFF_W + K_W;   // full-precision diff * gain

    typedef logic signed [E_W-1:0] sample_t;

endpackage

// File: rtl/differentiator_if.sv
// Sample-in / contribution-out bundle of the derivative term.
//
// Handshake: e_valid is a one-cycle strobe qualified by ena; there is no
// back-pressure, every strobe seen on an edge with ena=1 is accepted.
// d_valid is a one-cycle strobe marking the cycle after d_contrib/d_sat
// were updated; d_contrib/d_sat hold between strobes.
interface differentiator_if;
    import pid_pkg::*;

    logic           ena;
    sample_t        e;
    logic           e_valid;
    logic [K_W-1:0] K_d;
    sample_t        d_contrib;
    logic           d_valid;
    logic           d_sat;

    modport master (
        output ena, e, e_valid, K_d,
        input  d_contrib, d_valid, d_sat
    );

    modport slave (
        input  ena, e, e_valid, K_d,
        output d_contrib, d_valid, d_sat
    );

endinterface

// File: rtl/sat_clip.sv
// Signed saturation from IN_W to OUT_W bits with a clipped flag.
module sat_clip #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clipped
);

    // Largest / smallest value representable in OUT_W, held at IN_W width.
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    // Clamp out-of-range inputs, otherwise pass the low bits through.
    always_comb begin
        dout    = din[OUT_W-1:0];
        clipped = 1'b0;
        if (din > MAX_V) begin
            dout    = MAX_V[OUT_W-1:0];
            clipped = 1'b1;
        end else if (din < MIN_V) begin
            dout    = MIN_V[OUT_W-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/differentiator.sv
// Derivative term of the PID controller: two-stage pipeline.
//   S1: difference of successive samples, capture of the gain.
//   S2: scale by gain, drop fraction bits (floor), saturate, register.
// ena=0 freezes every register except d_valid, which is cleared so that a
// result is reported exactly once, on the first enabled edge after S1.
module differentiator
    import pid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    differentiator_if.slave  bus
);

    logic                     primed;
    sample_t                  e_prev;
    logic signed [DIFF_W-1:0] diff;
    logic [K_W-1:0]           k_q;
    logic                     s1_v;

    logic signed [DIFF_W-1:0] e_ext;
    logic signed [DIFF_W-1:0] prev_ext;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] k_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    sample_t                  clip_val;
    logic                     clip_flag;

    sample_t                  d_contrib_q;
    logic                     d_valid_q;
    logic                     d_sat_q;

    // One extra bit keeps e - e_prev exact over the full sample range.
    assign e_ext    = {bus.e[E_W-1], bus.e};
    assign prev_ext = {e_prev[E_W-1], e_prev};

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign diff_x  = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
    assign k_x     = {{(PROD_W-K_W){1'b0}}, k_q};
    assign prod    = diff_x * k_x;
    assign shifted = prod >>> FRAC;

    sat_clip #(
        .IN_W  (PROD_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .din     (shifted),
        .dout    (clip_val),
        .clipped (clip_flag)
    );

    // S1: take the difference against the previous sample; the first sample
    // after reset has no predecessor and yields a zero difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed <= 1'b0;
            e_prev <= '0;
            diff   <= '0;
            k_q    <= '0;
            s1_v   <= 1'b0;
        end else if (bus.ena) begin
            if (bus.e_valid) begin
                if (primed) begin
                    diff <= e_ext - prev_ext;
                end else begin
                    diff <= '0;
                end
                primed <= 1'b1;
                e_prev <= bus.e;
                k_q    <= bus.K_d;
                s1_v   <= 1'b1;
            end else begin
                s1_v   <= 1'b0;
            end
        end
    end

    // S2: register the saturated result; value and flag hold between updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_contrib_q <= '0;
            d_sat_q     <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            d_valid_q <= bus.ena & s1_v;
            if (bus.ena && s1_v) begin
                d_contrib_q <= clip_val;
                d_sat_q     <= clip_flag;
            end
        end
    end

    assign bus.d_contrib = d_contrib_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_sat     = d_sat_q;

endmodule

// File: tb/tb_differentiator.sv
// Directed bench for the derivative term: per-cycle comparison against an
// arithmetic model plus hand-computed literal expectations.
module tb_differentiator;
    import pid_pkg::*;

    logic clk = 1'b0;
    logic rst;

    differentiator_if bus ();

    differentiator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    // Result of one accepted sample: floor(diff * k / 2^FRAC), clamped.
    function automatic int floor_div4(input int p);
        int q;
        q = p / 4;
        if ((p % 4) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clamp8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    logic [8:0] exp_q[$];    // {sat, value} of results due on d_valid
    int   m_prev;
    logic m_primed;
    logic m_fv;              // an accepted sample awaits its output edge
    int   m_fval;
    int   m_fsat;
    int   exp_dv;
    int   exp_d;
    int   exp_sat;

    always @(posedge clk or posedge rst) begin
        int raw;
        int d;
        if (rst) begin
            m_prev = 0; m_primed = 1'b0; m_fv = 1'b0;
            m_fval = 0; m_fsat = 0;
            exp_dv = 0; exp_d = 0; exp_sat = 0;
            exp_q.delete();
        end else if (bus.ena) begin
            exp_dv = m_fv ? 1 : 0;
            if (m_fv) begin
                exp_d   = m_fval;
                exp_sat = m_fsat;
                exp_q.push_back({m_fsat[0], m_fval[7:0]});
            end
            if (bus.e_valid) begin
                d        = m_primed ? (int'(bus.e) - m_prev) : 0;
                raw      = floor_div4(d * int'(bus.K_d));
                m_fval   = clamp8(raw);
                m_fsat   = (raw != m_fval) ? 1 : 0;
                m_prev   = int'(bus.e);
                m_primed = 1'b1;
                m_fv     = 1'b1;
            end else begin
                m_fv = 1'b0;
            end
        end else begin
            exp_dv = 0;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [8:0] item;
        if (chk_en && !rst) begin
            check("cyc_d_valid", int'(bus.d_valid), exp_dv);
            check("cyc_d_contrib_hold", int'(bus.d_contrib), exp_d);
            check("cyc_d_sat_hold", int'(bus.d_sat), exp_sat);
            if (exp_dv != 0) begin
                if (exp_q.size() == 0) begin
                    check("sb_queue_nonempty", 0, 1);
                end else begin
                    item = exp_q.pop_front();
                    check("sb_d_contrib", int'(bus.d_contrib), int'($signed(item[7:0])));
                    check("sb_d_sat", int'(bus.d_sat), int'(item[8]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input int ev, input int kv);
        bus.e       = sample_t'(ev);
        bus.K_d     = 8'(kv);
        bus.e_valid = 1'b1;
        @(negedge clk);
        bus.e_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input int val, input int sat);
        @(negedge clk);
        check({name, "_valid"}, int'(bus.d_valid), 1);
        check({name, "_value"}, int'(bus.d_contrib), val);
        check({name, "_sat"}, int'(bus.d_sat), sat);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int b2b_e[4];
        int b2b_v[4];
        b2b_e = '{0, 4, 8, 12};
        b2b_v = '{0, 4, 4, 4};

        rst = 1'b1;
        bus.ena = 1'b1; bus.e = '0; bus.e_valid = 1'b0; bus.K_d = '0;
        repeat (2) @(negedge clk);
        check("rst_d_contrib", int'(bus.d_contrib), 0);
        check("rst_d_valid", int'(bus.d_valid), 0);
        check("rst_d_sat", int'(bus.d_sat), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // first sample yields zero; then diff=4, K=1.0
        strobe(10, 4);   expect_out("first_zero", 0, 0);
        strobe(14, 4);   expect_out("step4", 4, 0);
        // negative differences and floor rounding
        strobe(20, 4);   expect_out("step6", 6, 0);
        strobe(0, 4);    expect_out("neg20", -20, 0);
        strobe(-1, 1);   expect_out("floor_m1", -1, 0);
        // saturation at both rails (255*2=510, -255*2=-510)
        strobe(-128, 8); expect_out("sat_pre", -128, 1);
        strobe(127, 8);  expect_out("sat_pos", 127, 1);
        strobe(-128, 8); expect_out("sat_neg", -128, 1);

        // back-to-back strobes from a fresh reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.e = sample_t'(b2b_e[i]); bus.K_d = 8'd4; bus.e_valid = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                check("b2b_valid", int'(bus.d_valid), 1);
                check("b2b_value", int'(bus.d_contrib), b2b_v[i-1]);
            end
        end
        bus.e_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", int'(bus.d_valid), 1);
        check("b2b_last_value", int'(bus.d_contrib), b2b_v[3]);
        @(negedge clk);
        check("b2b_idle_valid", int'(bus.d_valid), 0);

        // stall: accepted sample waits through three disabled cycles
        bus.e = sample_t'(20); bus.K_d = 8'd4; bus.e_valid = 1'b1;
        @(negedge clk);
        bus.e_valid = 1'b0;
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_valid", int'(bus.d_valid), 0);
        end
        bus.ena = 1'b1;
        expect_out("stall_release", 8, 0);
        @(negedge clk);
        check("stall_after_valid", int'(bus.d_valid), 0);

        // reset one cycle after a strobe discards the in-flight sample
        strobe(50, 4);
        rst = 1'b1;
        #1;
        check("midrst_d_contrib", int'(bus.d_contrib), 0);
        check("midrst_d_valid", int'(bus.d_valid), 0);
        check("midrst_d_sat", int'(bus.d_sat), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_stale", int'(bus.d_valid), 0);
        strobe(7, 4);    expect_out("midrst_first", 0, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
